// File: rtl/hint_sequencer.sv
// rtl/hint_sequencer.sv - resolves one instruction's memory access set against an in-order hint stream
module hint_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic        rd0_en,
  input  logic        rd1_en,
  input  logic [31:0] rd0_addr,
  input  logic [31:0] rd1_addr,
  input  logic        wr0_en,
  input  logic        wr1_en,
  input  logic [31:0] wr0_addr,
  input  logic [31:0] wr1_addr,
  input  logic [31:0] wr0_data,
  input  logic [31:0] wr1_data,
  input  logic        hint_valid,
  output logic        hint_ready,
  input  logic        hint_is_write,
  input  logic [31:0] hint_address,
  input  logic [31:0] hint_data,
  output logic [31:0] rd0_data,
  output logic [31:0] rd1_data,
  output logic        done_valid,
  input  logic        done_ready,
  output logic        fault,
  output logic [2:0]  fault_code
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD0   = 3'd1,
    RD1   = 3'd2,
    WR0   = 3'd3,
    WR1   = 3'd4,
    DONE  = 3'd5,
    FAULT = 3'd6
  } state_t;

  state_t state, state_next;

  // Latched access set: enables in order {wr1, wr0, rd1, rd0}
  logic [3:0]       en_q;
  logic [31:0]      rd0_addr_q, rd1_addr_q, wr0_addr_q, wr1_addr_q;
  logic [31:0]      wr0_data_q, wr1_data_q;
  logic [CNT_W-1:0] cnt;

  logic        accept;
  logic        in_access;
  logic        hint_take;
  logic        timeout_hit;
  logic        exp_write;
  logic [31:0] exp_addr;
  logic [31:0] exp_data;
  logic [2:0]  next_pos;
  logic [2:0]  chk_code;

  // First enabled access at or after position start, in order RD0, RD1, WR0, WR1
  function automatic state_t first_from(input logic [3:0] en, input logic [2:0] start);
    if (start <= 3'd0 && en[0])      first_from = RD0;
    else if (start <= 3'd1 && en[1]) first_from = RD1;
    else if (start <= 3'd2 && en[2]) first_from = WR0;
    else if (start <= 3'd3 && en[3]) first_from = WR1;
    else                             first_from = DONE;
  endfunction

  assign accept      = instr_valid && instr_ready;
  assign in_access   = (state == RD0) || (state == RD1) || (state == WR0) || (state == WR1);
  assign hint_take   = hint_valid && in_access;
  assign timeout_hit = !hint_valid && (cnt == CNT_W'(TIMEOUT - 1));

  assign instr_ready = (state == IDLE) && rst_n;
  assign hint_ready  = in_access;
  assign done_valid  = (state == DONE);
  assign fault       = (state == FAULT);

  // Expected hint for the current access and the search position after it
  always_comb begin
    exp_write = 1'b0;
    exp_addr  = '0;
    exp_data  = '0;
    next_pos  = 3'd4;
    case (state)
      RD0: begin exp_addr = rd0_addr_q; next_pos = 3'd1; end
      RD1: begin exp_addr = rd1_addr_q; next_pos = 3'd2; end
      WR0: begin exp_write = 1'b1; exp_addr = wr0_addr_q; exp_data = wr0_data_q; next_pos = 3'd3; end
      WR1: begin exp_write = 1'b1; exp_addr = wr1_addr_q; exp_data = wr1_data_q; next_pos = 3'd4; end
      default: ;
    endcase
  end

  // Hint check, first failure wins: kind, then address, then data on writes
  always_comb begin
    chk_code = 3'd0;
    if (hint_is_write != exp_write)          chk_code = 3'd1;
    else if (hint_address != exp_addr)       chk_code = 3'd2;
    else if (exp_write && hint_data != exp_data) chk_code = 3'd3;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = first_from({wr1_en, wr0_en, rd1_en, rd0_en}, 3'd0);
      RD0, RD1, WR0, WR1: begin
        if (hint_valid) state_next = (chk_code != 3'd0) ? FAULT : first_from(en_q, next_pos);
        else if (timeout_hit) state_next = FAULT;
      end
      DONE:    if (done_ready) state_next = IDLE;
      FAULT:   state_next = FAULT;
      default: state_next = IDLE;
    endcase
  end

  // Access-set latch, read results, fault code and idle-cycle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q       <= '0;
      rd0_addr_q <= '0;
      rd1_addr_q <= '0;
      wr0_addr_q <= '0;
      wr1_addr_q <= '0;
      wr0_data_q <= '0;
      wr1_data_q <= '0;
      rd0_data   <= '0;
      rd1_data   <= '0;
      fault_code <= '0;
      cnt        <= '0;
    end else begin
      if (accept) begin
        en_q       <= {wr1_en, wr0_en, rd1_en, rd0_en};
        rd0_addr_q <= rd0_addr;
        rd1_addr_q <= rd1_addr;
        wr0_addr_q <= wr0_addr;
        wr1_addr_q <= wr1_addr;
        wr0_data_q <= wr0_data;
        wr1_data_q <= wr1_data;
        rd0_data   <= '0;
        rd1_data   <= '0;
      end
      if (hint_take && chk_code == 3'd0) begin
        if (state == RD0) rd0_data <= hint_data;
        if (state == RD1) rd1_data <= hint_data;
      end
      if (state_next == FAULT && state != FAULT)
        fault_code <= hint_valid ? chk_code : 3'd4;
      // Every consumed hint moves to a new state, so clearing on a take also covers state entry
      if (hint_take || !in_access) cnt <= '0;
      else                         cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hint_sequencer.sv
// tb/tb_hint_sequencer.sv - scoreboard bench for hint_sequencer
module tb_hint_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid, instr_ready;
  logic        rd0_en, rd1_en, wr0_en, wr1_en;
  logic [31:0] rd0_addr, rd1_addr, wr0_addr, wr1_addr, wr0_data, wr1_data;
  logic        hint_valid, hint_ready, hint_is_write;
  logic [31:0] hint_address, hint_data;
  logic [31:0] rd0_data, rd1_data;
  logic        done_valid, done_ready;
  logic        fault;
  logic [2:0]  fault_code;

  always #5 clk = ~clk;

  hint_sequencer #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .rd0_en(rd0_en), .rd1_en(rd1_en), .rd0_addr(rd0_addr), .rd1_addr(rd1_addr),
    .wr0_en(wr0_en), .wr1_en(wr1_en), .wr0_addr(wr0_addr), .wr1_addr(wr1_addr),
    .wr0_data(wr0_data), .wr1_data(wr1_data),
    .hint_valid(hint_valid), .hint_ready(hint_ready), .hint_is_write(hint_is_write),
    .hint_address(hint_address), .hint_data(hint_data),
    .rd0_data(rd0_data), .rd1_data(rd1_data),
    .done_valid(done_valid), .done_ready(done_ready),
    .fault(fault), .fault_code(fault_code)
  );

  typedef struct packed {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
  } hint_t;

  hint_t       hq[$];
  logic [63:0] exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  int lat, flat, taken, dv_cyc;
  bit got_done;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_instr(input logic [3:0] en, input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] a2, input logic [31:0] a3,
                           input logic [31:0] d2, input logic [31:0] d3);
    {wr1_en, wr0_en, rd1_en, rd0_en} = en;
    rd0_addr = a0; rd1_addr = a1; wr0_addr = a2; wr1_addr = a3;
    wr0_data = d2; wr1_data = d3;
  endtask

  function automatic hint_t mk(input logic w, input logic [31:0] a, input logic [31:0] d);
    hint_t h;
    h.w = w; h.a = a; h.d = d;
    return h;
  endfunction

  // Offer one instruction and feed queued hints; each hint waits 'delay' cycles in its state
  task automatic run(input int hold, input int delay, input int budget,
                     output int o_lat, output int o_flat, output int o_taken,
                     output int o_dv, output bit o_done);
    bit accepted, hv, hr, ir;
    int acc_cyc, ref_cyc;
    logic [63:0] e;
    accepted = 0; acc_cyc = 0; ref_cyc = 0;
    o_lat = -1; o_flat = -1; o_taken = 0; o_dv = 0; o_done = 0;
    instr_valid = 1'b1;
    done_ready  = 1'b0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      hv = (hq.size() > 0) && (delay == 0 || (accepted && cyc >= ref_cyc + delay));
      hint_valid = hv;
      if (hv) {hint_is_write, hint_address, hint_data} = hq[0];
      hr = hint_ready;
      ir = instr_ready;
      if (fault) begin
        o_flat = cyc - acc_cyc;
        break;
      end
      if (done_valid) begin
        if (o_lat < 0) o_lat = cyc - acc_cyc;
        o_dv++;
        done_ready = (o_dv > hold);
        if (done_ready) begin
          if (exp_q.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
          else begin
            e = exp_q.pop_front();
            chk("rd0_data", {32'd0, rd0_data}, {32'd0, e[63:32]});
            chk("rd1_data", {32'd0, rd1_data}, {32'd0, e[31:0]});
          end
        end
      end else begin
        done_ready = 1'b0;
      end
      @(posedge clk); #1;
      if (hv && hr) begin
        void'(hq.pop_front());
        o_taken++;
        ref_cyc = cyc + 1;
      end
      if (instr_valid && ir) begin
        accepted = 1; acc_cyc = cyc; ref_cyc = cyc + 1;
        instr_valid = 1'b0;
        // Scramble the offered set: the DUT must work from its latched copy
        rd0_addr = $urandom; rd1_addr = $urandom; wr0_addr = $urandom; wr1_addr = $urandom;
        wr0_data = $urandom; wr1_data = $urandom;
        {wr1_en, wr0_en, rd1_en, rd0_en} = 4'($urandom);
      end
      if (done_ready) begin
        o_done = 1;
        break;
      end
    end
    instr_valid = 1'b0;
    hint_valid  = 1'b0;
    done_ready  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    hq.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] ra, rdv;
    rst_n = 1'b0;
    instr_valid = 0; done_ready = 0; hint_valid = 0; hint_is_write = 0;
    hint_address = 0; hint_data = 0;
    set_instr(4'b0000, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    instr_valid = 1'b1;
    hint_valid  = 1'b1;
    #1;
    chk("rst_instr_ready", {63'd0, instr_ready}, 64'd0);
    chk("rst_hint_ready", {63'd0, hint_ready}, 64'd0);
    chk("rst_done_valid", {63'd0, done_valid}, 64'd0);
    chk("rst_fault", {63'd0, fault}, 64'd0);
    chk("rst_fault_code", {61'd0, fault_code}, 64'd0);
    chk("rst_rd_data", {rd0_data, rd1_data}, 64'd0);
    instr_valid = 1'b0;
    hint_valid  = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;

    // Single read
    set_instr(4'b0001, 32'h1000, 0, 0, 0, 0, 0);
    hq.push_back(mk(1'b0, 32'h1000, 32'hDEADBEEF));
    exp_q.push_back({32'hDEADBEEF, 32'd0});
    run(0, 0, 50, lat, flat, taken, dv_cyc, got_done);
    chk("rd0_done", {63'd0, got_done}, 64'd1);
    chk("rd0_latency", 64'(lat), 64'd2);
    chk("rd0_taken", 64'(taken), 64'd1);
    chk("b2b_ready", {63'd0, instr_ready}, 64'd1);
    repeat (3) @(posedge clk);
    #1 chk("rd0_stable", {32'd0, rd0_data}, 64'hDEADBEEF);

    // All four accesses, both reads to the same address
    set_instr(4'b1111, 32'h3000, 32'h3000, 32'h4000, 32'h4004, 32'h11, 32'h22);
    hq.push_back(mk(1'b0, 32'h3000, 32'hA));
    hq.push_back(mk(1'b0, 32'h3000, 32'hB));
    hq.push_back(mk(1'b1, 32'h4000, 32'h11));
    hq.push_back(mk(1'b1, 32'h4004, 32'h22));
    exp_q.push_back({32'hA, 32'hB});
    run(0, 0, 50, lat, flat, taken, dv_cyc, got_done);
    chk("all4_done", {63'd0, got_done}, 64'd1);
    chk("all4_latency", 64'(lat), 64'd5);
    chk("all4_taken", 64'(taken), 64'd4);

    // rd0 + wr0
    set_instr(4'b0101, 32'h7000, 0, 32'h7100, 0, 32'h99, 0);
    hq.push_back(mk(1'b0, 32'h7000, 32'h1234));
    hq.push_back(mk(1'b1, 32'h7100, 32'h99));
    exp_q.push_back({32'h1234, 32'd0});
    run(0, 0, 50, lat, flat, taken, dv_cyc, got_done);
    chk("mix_latency", 64'(lat), 64'd3);

    // Random rd1-only sets
    for (int i = 0; i < 3; i++) begin
      ra = $urandom; rdv = $urandom;
      set_instr(4'b0010, 0, ra, 0, 0, 0, 0);
      hq.push_back(mk(1'b0, ra, rdv));
      exp_q.push_back({32'd0, rdv});
      run(0, 0, 50, lat, flat, taken, dv_cyc, got_done);
      chk("rd1_latency", 64'(lat), 64'd2);
    end

    // No enables, done held 5 cycles
    set_instr(4'b0000, 0, 0, 0, 0, 0, 0);
    hq.push_back(mk(1'b0, 32'h0, 32'h5555));
    exp_q.push_back(64'd0);
    run(5, 0, 50, lat, flat, taken, dv_cyc, got_done);
    chk("none_latency", 64'(lat), 64'd1);
    chk("none_taken", 64'(taken), 64'd0);
    chk("none_hold", 64'(dv_cyc), 64'd6);
    chk("none_b2b_ready", {63'd0, instr_ready}, 64'd1);
    hq.delete();

    // Hints arriving on the last idle cycle before timeout, twice
    set_instr(4'b0011, 32'h8000, 32'h8008, 0, 0, 0, 0);
    hq.push_back(mk(1'b0, 32'h8000, 32'h1));
    hq.push_back(mk(1'b0, 32'h8008, 32'h2));
    exp_q.push_back({32'h1, 32'h2});
    run(0, 15, 100, lat, flat, taken, dv_cyc, got_done);
    chk("late_done", {63'd0, got_done}, 64'd1);
    chk("late_latency", 64'(lat), 64'd33);

    // Timeout
    set_instr(4'b0001, 32'h9000, 0, 0, 0, 0, 0);
    run(0, 0, 40, lat, flat, taken, dv_cyc, got_done);
    chk("to_fault_cycle", 64'(flat), 64'd17);
    chk("to_code", {61'd0, fault_code}, 64'd4);
    chk("to_no_done", {63'd0, got_done}, 64'd0);
    do_reset();

    // Address mismatch on second hint; fault is terminal
    set_instr(4'b0111, 32'h1000, 32'h2000, 32'h3000, 0, 32'h5, 0);
    hq.push_back(mk(1'b0, 32'h1000, 32'h1));
    hq.push_back(mk(1'b0, 32'h2004, 32'h2));
    hq.push_back(mk(1'b1, 32'h3000, 32'h5));
    run(0, 0, 50, lat, flat, taken, dv_cyc, got_done);
    chk("addr_code", {61'd0, fault_code}, 64'd2);
    chk("addr_taken", 64'(taken), 64'd2);
    chk("addr_no_done", 64'(lat), 64'hFFFF_FFFF_FFFF_FFFF);
    instr_valid = 1'b1;
    hint_valid  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("fault_sticky", {60'd0, fault, fault_code}, 64'hA);
    chk("fault_ready", {62'd0, instr_ready, hint_ready}, 64'd0);
    chk("fault_done_valid", {63'd0, done_valid}, 64'd0);
    instr_valid = 1'b0;
    hint_valid  = 1'b0;
    do_reset();

    // Write data mismatch
    set_instr(4'b0100, 0, 0, 32'h5000, 0, 32'h5, 0);
    hq.push_back(mk(1'b1, 32'h5000, 32'h6));
    run(0, 0, 50, lat, flat, taken, dv_cyc, got_done);
    chk("data_code", {61'd0, fault_code}, 64'd3);
    do_reset();

    // Read hint for a write, also with wrong address and data: kind wins
    set_instr(4'b0100, 0, 0, 32'h5000, 0, 32'h5, 0);
    hq.push_back(mk(1'b0, 32'h5004, 32'h6));
    run(0, 0, 50, lat, flat, taken, dv_cyc, got_done);
    chk("kind_code", {61'd0, fault_code}, 64'd1);
    do_reset();

    // Wrong address and data on a write: address wins
    set_instr(4'b0100, 0, 0, 32'h5000, 0, 32'h5, 0);
    hq.push_back(mk(1'b1, 32'h5004, 32'h6));
    run(0, 0, 50, lat, flat, taken, dv_cyc, got_done);
    chk("prio_code", {61'd0, fault_code}, 64'd2);
    do_reset();

    // Reset while waiting in RD1
    set_instr(4'b0011, 32'h6000, 32'h6004, 0, 0, 0, 0);
    hq.push_back(mk(1'b0, 32'h6000, 32'h77));
    run(0, 0, 4, lat, flat, taken, dv_cyc, got_done);
    chk("mid_rd0", {32'd0, rd0_data}, 64'h77);
    chk("mid_hint_ready", {63'd0, hint_ready}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", {62'd0, instr_ready, hint_ready}, 64'd0);
    chk("mid_rst_outs", {rd0_data, rd1_data}, 64'd0);
    chk("mid_rst_flags", {59'd0, done_valid, fault, fault_code}, 64'd0);
    do_reset();
    set_instr(4'b0011, 32'h6000, 32'h6004, 0, 0, 0, 0);
    hq.push_back(mk(1'b0, 32'h6000, 32'h88));
    hq.push_back(mk(1'b0, 32'h6004, 32'h99));
    exp_q.push_back({32'h88, 32'h99});
    run(0, 0, 50, lat, flat, taken, dv_cyc, got_done);
    chk("fresh_latency", 64'(lat), 64'd3);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hint_sequencer.md
HINT_SEQUENCER -- requirements
Module: hint_sequencer

Interface
REQ-001 The block SHALL expose parameter TIMEOUT, default 16, meaning the maximum number of idle cycles waiting for a hint in any access state.
REQ-002 The block SHALL expose parameter CNT_W, default 5, meaning the timeout counter width; CNT_W SHALL hold TIMEOUT.
REQ-003 The block SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  single clock, all state on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr_valid  in  1  an instruction's access set is offered.
- instr_ready  out  1  the block accepts an access set.
- rd0_en, rd1_en  in  1 each  operand#0 / operand#1 memory read required.
- rd0_addr, rd1_addr  in  32 each  read effective addresses.
- wr0_en, wr1_en  in  1 each  dest0 / dest1 memory write required.
- wr0_addr, wr1_addr  in  32 each  write addresses.
- wr0_data, wr1_data  in  32 each  expected write data.
- hint_valid  in  1  hint stream entry present.
- hint_ready  out  1  hint consumed this cycle.
- hint_is_write  in  1  hint kind.
- hint_address  in  32  hint address.
- hint_data  in  32  hint data.
- rd0_data, rd1_data  out  32 each  resolved read values.
- done_valid  out  1  access set fully resolved.
- done_ready  in  1  consumer accepts done.
- fault  out  1  sticky hint-check failure.
- fault_code  out  3  1 kind, 2 address, 3 data, 4 timeout.

Function
REQ-004 States SHALL be IDLE, RD0, RD1, WR0, WR1, DONE, FAULT.
REQ-005 instr_ready SHALL be 1 only in IDLE with rst_n high.
REQ-006 On instr_valid&&instr_ready, all enables, addresses and write data SHALL be latched; rd0_data/rd1_data SHALL be cleared to 0.
REQ-007 After acceptance, the next state SHALL be the first enabled access in fixed order RD0, RD1, WR0, WR1; with no enables it SHALL be DONE.
REQ-008 In each access state, hint_ready SHALL be 1, and one hint SHALL be consumed per access, including when rd0_addr equals rd1_addr.
REQ-009 On hint_valid in an access state, checks SHALL use priority kind > address > data (data checked in WR states only); a pass SHALL advance to the next enabled access, or to DONE.
REQ-010 A pass in RD0/RD1 SHALL latch hint_data into rd0_data/rd1_data.
REQ-011 A check failure SHALL go to FAULT with the first failing code latched into fault_code.
REQ-012 The timeout counter SHALL reset on entry to each access state and on each accepted hint, and SHALL increment per cycle with hint_valid low; reaching TIMEOUT SHALL go to FAULT with code 4.
REQ-013 With hints always valid and N enabled accesses, done_valid SHALL rise N+1 cycles after the acceptance edge (N=0 gives 1 cycle).
REQ-014 In DONE, done_valid SHALL be 1 and held until done_ready, then the block SHALL return to IDLE; back-to-back acceptance is allowed on the following cycle.
REQ-015 rd0_data/rd1_data SHALL stay stable from DONE until the next acceptance.
REQ-016 FAULT SHALL be terminal until reset: fault=1, instr_ready=0, hint_ready=0, done_valid=0.
REQ-017 hint_ready SHALL be 0 in IDLE, DONE and FAULT; hints offered there SHALL NOT be consumed.

Reset
REQ-018 While rst_n is low: state IDLE, instr_ready=0, hint_ready=0, done_valid=0, fault=0, fault_code=0, rd0_data=rd1_data=0, counter 0.
REQ-019 Reset asserted mid-sequence SHALL abandon the access set immediately; no hint SHALL be consumed on that edge.

Verification
REQ-020 rd0_en=1 with rd0_addr=0x1000, and hint {read, 0x1000, 0xDEADBEEF} valid -> rd0_data=0xDEADBEEF, done_valid exactly 2 cycles after acceptance.
REQ-021 rd0, rd1 and wr0 enabled, with the second hint address 0x2004 against expected 0x2000 -> fault=1, fault_code=2, only 2 hints consumed, done_valid never asserted.
REQ-022 wr0_en=1 with wr0_data=0x5, and hint {write, same address, 0x6} -> fault_code=3. In a separate run, a read hint offered for a WR state -> fault_code=1.
REQ-023 rd0_en=1 and hint_valid held low for 16 cycles -> FAULT with code 4 on the 16th cycle; a hint arriving at cycle 15 passes normally.
REQ-024 All enables 0 -> done_valid after 1 cycle with no hints consumed. With done_ready held low for 5 cycles, done_valid is held; the next instruction is accepted the cycle after the handshake.
REQ-025 rst_n pulsed low while in RD1 -> all outputs return to reset values, and a fresh instruction completes normally.
